// File: rtl/int_to_float_sequencer.sv
// Multi-cycle integer-to-float converter: one leading-one detector and one normalising
// shifter sequenced through detect/shift/round, with valid/ready on both sides.
module int_to_float_sequencer #(
   parameter int INT_SIZE      = 32,
   parameter int EXPONENT_SIZE = 8,
   parameter int MANTISSA_SIZE = 23
) (
   input  logic                                   aclk,
   input  logic                                   resetn,
   input  logic                                   s_valid,
   output logic                                   s_ready,
   input  logic [INT_SIZE-1:0]                    s_data,
   input  logic                                   s_signed,
   output logic                                   m_valid,
   input  logic                                   m_ready,
   output logic [EXPONENT_SIZE+MANTISSA_SIZE:0]   m_data
);

   localparam int PW = (INT_SIZE > 1) ? $clog2(INT_SIZE) : 1;
   localparam int FW = INT_SIZE - 1;
   localparam int XW = FW + MANTISSA_SIZE + 2;
   localparam logic [EXPONENT_SIZE-1:0] BIAS = {1'b0, {(EXPONENT_SIZE-1){1'b1}}};

   generate
      if (INT_SIZE > 2**(EXPONENT_SIZE-1) || INT_SIZE < 2) begin : g_param_check
         $error("int_to_float_sequencer: INT_SIZE must be in 2..2**(EXPONENT_SIZE-1)");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, DETECT, SHIFT, ROUND, OUT} state_t;

   state_t                    state;
   logic                      sign_q;
   logic [INT_SIZE-1:0]       mag_q;
   logic [PW-1:0]             pos_q;
   logic [FW-1:0]             norm_q;

   // Leading-one detector: the last set bit seen while scanning upward wins.
   logic [PW-1:0]             lod_pos;
   always_comb begin
      lod_pos = '0;
      for (int i = 0; i < INT_SIZE; i++) begin
         if (mag_q[i]) lod_pos = PW'(i);
      end
   end

   logic [PW-1:0]             shift_amt;
   assign shift_amt = PW'(INT_SIZE - 1) - pos_q;

   // The normalised leading one is implicit, so only the fraction bits below it are kept.
   logic [XW-1:0]             frac_ext;
   logic [MANTISSA_SIZE-1:0]  man_trunc;
   logic                      guard_bit;
   logic                      sticky_bit;
   logic                      round_inc;
   logic [MANTISSA_SIZE:0]    man_sum;
   logic [EXPONENT_SIZE-1:0]  exp_base;
   logic [EXPONENT_SIZE-1:0]  exp_final;

   assign frac_ext   = {norm_q, {(MANTISSA_SIZE+2){1'b0}}};
   assign man_trunc  = frac_ext[XW-1 -: MANTISSA_SIZE];
   assign guard_bit  = frac_ext[FW+1];
   assign sticky_bit = |frac_ext[FW:0];
   assign round_inc  = guard_bit & (sticky_bit | man_trunc[0]);
   assign man_sum    = {1'b0, man_trunc} + {{MANTISSA_SIZE{1'b0}}, round_inc};
   assign exp_base   = BIAS + EXPONENT_SIZE'(pos_q);
   assign exp_final  = exp_base + {{(EXPONENT_SIZE-1){1'b0}}, man_sum[MANTISSA_SIZE]};

   // Sequencer: one state per cycle, outputs registered and changed only on loads.
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         s_ready <= 1'b1;
         m_valid <= 1'b0;
         m_data  <= '0;
         sign_q  <= 1'b0;
         mag_q   <= '0;
         pos_q   <= '0;
         norm_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (s_valid && s_ready) begin
                  sign_q  <= s_signed & s_data[INT_SIZE-1];
                  mag_q   <= (s_signed & s_data[INT_SIZE-1]) ? (~s_data + INT_SIZE'(1)) : s_data;
                  s_ready <= 1'b0;
                  state   <= DETECT;
               end
            end
            DETECT: begin
               pos_q <= lod_pos;
               if (mag_q == '0) begin
                  m_data  <= '0;
                  m_valid <= 1'b1;
                  state   <= OUT;
               end else begin
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               norm_q <= FW'(mag_q << shift_amt);
               state  <= ROUND;
            end
            ROUND: begin
               m_data  <= {sign_q, exp_final, man_sum[MANTISSA_SIZE-1:0]};
               m_valid <= 1'b1;
               state   <= OUT;
            end
            OUT: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  s_ready <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               s_ready <= 1'b1;
               m_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_to_float_sequencer.sv
// Self-checking bench for int_to_float_sequencer: directed corner cases, random operands
// against an arithmetic reference model, backpressure, back-to-back and mid-flight reset.
module tb_int_to_float_sequencer;

   logic        aclk = 1'b0;
   logic        resetn = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] s_data = '0;
   logic        s_signed = 1'b0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [31:0] m_data;

   int checkCount = 0;
   int passCount  = 0;
   int cycleCount = 0;

   logic        collect = 1'b0;
   logic [31:0] resultQ[$];

   int          lat;
   logic [31:0] res;
   logic [31:0] held;
   logic [31:0] ops[3];
   int          acc[3];
   int          highCount;
   int          waitCount;
   logic [31:0] rd;
   logic        rs;

   int_to_float_sequencer #(
      .INT_SIZE(32),
      .EXPONENT_SIZE(8),
      .MANTISSA_SIZE(23)
   ) dut (
      .aclk(aclk),
      .resetn(resetn),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_data(s_data),
      .s_signed(s_signed),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_data(m_data)
   );

   always #5 aclk = ~aclk;

   always @(posedge aclk) cycleCount <= cycleCount + 1;

   // Output monitor used by the back-to-back test to collect results in order.
   always @(negedge aclk) begin
      if (collect && m_valid && m_ready) resultQ.push_back(m_data);
   end

   // Reference: exact magnitude, find the top bit, round the quotient to nearest-even.
   function automatic logic [31:0] refFloat(input logic [31:0] d, input logic sg);
      logic          neg;
      longint        mag;
      longint        q;
      longint        rem;
      longint        half;
      int            p;
      logic [63:0]   qv;
      neg = sg && d[31];
      mag = longint'({32'b0, d});
      if (neg) mag = 64'sh1_0000_0000 - mag;
      if (mag == 0) return 32'h0;
      p = 0;
      while ((mag >> (p + 1)) != 0) p++;
      if (p > 23) begin
         q    = mag >> (p - 23);
         rem  = mag - (q << (p - 23));
         half = 64'sd1 << (p - 24);
         qv   = q;
         if (rem > half || (rem == half && qv[0])) q = q + 1;
         if (q == (64'sd1 << 24)) begin
            q = q >> 1;
            p = p + 1;
         end
      end else begin
         q = mag << (23 - p);
      end
      qv = q;
      return {neg, 8'(p + 127), qv[22:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   // Offer one operand, wait for the result and, when m_ready is high, complete the handshake.
   task automatic applyStimulus(input logic [31:0] d, input logic sg, output int latency, output logic [31:0] result);
      int n;
      n = 0;
      while (!s_ready && n < 30) begin
         @(posedge aclk); #1;
         n++;
      end
      s_data   = d;
      s_signed = sg;
      s_valid  = 1'b1;
      @(posedge aclk); #1;
      s_valid = 1'b0;
      latency = 1;
      while (!m_valid && latency < 20) begin
         @(posedge aclk); #1;
         latency++;
      end
      result = m_data;
      if (m_ready) begin
         @(posedge aclk); #1;
      end
   endtask

   task automatic runCase(input logic [31:0] d, input logic sg, input logic [31:0] expected, input string tag);
      int          l;
      logic [31:0] r;
      applyStimulus(d, sg, l, r);
      checkOutput({tag, " data"}, 64'(r), 64'(expected));
      checkOutput({tag, " latency"}, 64'(l), (d == 32'h0) ? 64'd2 : 64'd4);
      checkOutput({tag, " s_ready after"}, 64'(s_ready), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #12;
      checkOutput("reset s_ready", 64'(s_ready), 64'd1);
      checkOutput("reset m_valid", 64'(m_valid), 64'd0);
      checkOutput("reset m_data", 64'(m_data), 64'd0);
      #10 resetn = 1'b1;
      @(posedge aclk); #1;

      runCase(32'h0000_0001, 1'b1, 32'h3F80_0000, "one");
      runCase(32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, "minus one");
      runCase(32'h0000_0000, 1'b1, 32'h0000_0000, "zero signed");
      runCase(32'h0000_0000, 1'b0, 32'h0000_0000, "zero unsigned");
      runCase(32'h8000_0000, 1'b1, 32'hCF00_0000, "most negative");
      runCase(32'h8000_0000, 1'b0, 32'h4F00_0000, "2^31 unsigned");
      runCase(32'h0100_0001, 1'b0, 32'h4B80_0000, "tie to even");
      runCase(32'h0100_0003, 1'b0, 32'h4B80_0002, "tie round up");
      runCase(32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, "exponent carry");

      for (int i = 0; i < 40; i++) begin
         rd = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 3) == 0) rd = -rd;
         rs = 1'($urandom_range(0, 1));
         runCase(rd, rs, refFloat(rd, rs), $sformatf("random %0d (0x%0h s=%0d)", i, rd, rs));
      end

      // Backpressure: result must hold while the consumer stalls.
      m_ready = 1'b0;
      applyStimulus(32'h0000_1234, 1'b0, lat, res);
      checkOutput("stall data", 64'(res), 64'(refFloat(32'h0000_1234, 1'b0)));
      held = res;
      for (int i = 0; i < 6; i++) begin
         @(posedge aclk); #1;
         checkOutput($sformatf("stall %0d m_valid", i), 64'(m_valid), 64'd1);
         checkOutput($sformatf("stall %0d m_data", i), 64'(m_data), 64'(held));
         checkOutput($sformatf("stall %0d s_ready", i), 64'(s_ready), 64'd0);
      end
      m_ready = 1'b1;
      @(posedge aclk); #1;
      checkOutput("release s_ready", 64'(s_ready), 64'd1);
      checkOutput("release m_valid", 64'(m_valid), 64'd0);

      // Back-to-back with s_valid held high.
      for (int k = 0; k < 3; k++) ops[k] = $urandom | 32'h1;
      resultQ.delete();
      collect = 1'b1;
      s_valid = 1'b1;
      s_signed = 1'b1;
      for (int k = 0; k < 3; k++) begin
         s_data = ops[k];
         waitCount = 0;
         while (!s_ready && waitCount < 30) begin
            @(posedge aclk); #1;
            waitCount++;
         end
         acc[k] = cycleCount + 1;
         @(posedge aclk); #1;
      end
      s_valid = 1'b0;
      waitCount = 0;
      while (resultQ.size() < 3 && waitCount < 30) begin
         @(posedge aclk); #1;
         waitCount++;
      end
      collect = 1'b0;
      checkOutput("b2b result count", 64'(resultQ.size()), 64'd3);
      for (int k = 0; k < 3; k++) begin
         if (k < resultQ.size())
            checkOutput($sformatf("b2b result %0d", k), 64'(resultQ[k]), 64'(refFloat(ops[k], 1'b1)));
      end
      checkOutput("b2b interval 0-1", 64'(acc[1] - acc[0]), 64'd5);
      checkOutput("b2b interval 1-2", 64'(acc[2] - acc[1]), 64'd5);

      // Reset while the conversion is in SHIFT.
      s_data   = 32'h0001_2345;
      s_signed = 1'b0;
      s_valid  = 1'b1;
      @(posedge aclk); #1;
      s_valid = 1'b0;
      @(posedge aclk); #1;
      resetn = 1'b0;
      #1;
      checkOutput("abort m_valid", 64'(m_valid), 64'd0);
      checkOutput("abort m_data", 64'(m_data), 64'd0);
      checkOutput("abort s_ready", 64'(s_ready), 64'd1);
      @(posedge aclk); #1;
      resetn = 1'b1;
      highCount = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge aclk); #1;
         if (m_valid) highCount++;
      end
      checkOutput("no stale result", 64'(highCount), 64'd0);
      runCase(32'h0001_2345, 1'b0, refFloat(32'h0001_2345, 1'b0), "after abort");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
